final_soc_key_poller: RTL and testbench

FINAL_SOC_KEY_POLLER -- requirements
Module: final_soc_key_poller

---
 rtl/final_soc_key_poller.sv | 180 ++++++++++++++++++
 tb/tb_final_soc_key_poller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/final_soc_key_poller.sv
// -----------------------------------------------------------------------------
// final_soc_key_poller
//
// Purpose:
//   Periodically reads a 4-bit key register over an Avalon-MM master port,
//   debounces the sampled levels and reports the debounced key state plus
//   one-cycle press/release pulses per key.
//
// Parameters:
//   POLL_DIV     - idle cycles between polls (>= 1)
//   DEBOUNCE_CNT - consecutive identical samples needed to accept a change (1..15)
//   ACTIVE_LOW   - 1: raw key bits are inverted so that a pressed key reads as 1
//
// Ports:
//   clk             in   sole clock, rising edge
//   reset           in   synchronous, active-high
//   avm_address     out  [1:0] Avalon-MM address, always 0
//   avm_read        out  Avalon-MM read request
//   avm_waitrequest in   Avalon-MM slave stall
//   avm_readdata    in   [31:0] Avalon-MM read data, bits [3:0] used
//   key_state       out  [3:0] debounced key levels, 1 = pressed
//   key_press       out  [3:0] one-cycle pulse on accepted 0->1
//   key_release     out  [3:0] one-cycle pulse on accepted 1->0
//
// Optional feature (macro FINAL_SOC_KEY_POLLER_IRQ_EN):
//   irq             out  sticky interrupt, set by any key_press bit
//   irq_ack         in   clears irq in a cycle with no key_press
//
// Handshake: a read is issued by holding avm_read=1 (address 0) in READ; the
// transfer completes on the rising edge where avm_read=1 and
// avm_waitrequest=0. Read data is valid one cycle later (the CAPTURE cycle).
// -----------------------------------------------------------------------------
module final_soc_key_poller #(
    parameter int POLL_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [3:0]  key_state,
    output logic [3:0]  key_press,
    output logic [3:0]  key_release
`ifdef FINAL_SOC_KEY_POLLER_IRQ_EN
    ,
    output logic        irq,
    input  logic        irq_ack
`endif
);

    localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [TW-1:0] RELOAD     = TW'(POLL_DIV - 1);
    localparam logic [3:0]    CNT_THRESH = 4'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;

    logic [3:0] last_sample;
    logic [3:0] stable_cnt;
    logic [3:0] sample;
    logic       same;
    logic [3:0] cnt_upd;
    logic       accept;
    logic [3:0] press_next;
    logic [3:0] release_next;

    // Only the low nibble of the read data carries key levels.
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata[31:4];

    assign avm_address = 2'd0;
    // Read request is a pure decode of the state register, so it can only be
    // high in READ and drops on the same edge that leaves READ (or resets).
    assign avm_read    = (state == S_READ);

    // -------------------------------------------------------------------------
    // Poll sequencer: next state / timer
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        timer_next = timer;
        case (state)
            S_IDLE: begin
                if (timer == '0) begin
                    state_next = S_READ;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            S_READ: begin
                if (!avm_waitrequest) begin
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_next = S_IDLE;
                timer_next = RELOAD;
            end
            default: begin
                state_next = S_IDLE;
                timer_next = RELOAD;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Debounce decision, evaluated on the CAPTURE cycle's read data
    // -------------------------------------------------------------------------
    always_comb begin
        sample       = (ACTIVE_LOW != 0) ? ~avm_readdata[3:0] : avm_readdata[3:0];
        same         = (sample == last_sample);
        cnt_upd      = 4'd0;
        if (same) begin
            cnt_upd = (stable_cnt == 4'd15) ? 4'd15 : stable_cnt + 4'd1;
        end
        // A sample that differs from the previous one restarts the count and
        // is never accepted, even when DEBOUNCE_CNT is 1.
        accept       = (state == S_CAPTURE) && same &&
                       (cnt_upd >= CNT_THRESH) && (sample != key_state);
        press_next   = 4'd0;
        release_next = 4'd0;
        if (accept) begin
            press_next   = sample & ~key_state;
            release_next = ~sample & key_state;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            timer       <= RELOAD;
            key_state   <= 4'd0;
            key_press   <= 4'd0;
            key_release <= 4'd0;
            last_sample <= 4'd0;
            stable_cnt  <= 4'd0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            key_press   <= press_next;
            key_release <= release_next;
            if (state == S_CAPTURE) begin
                last_sample <= sample;
                stable_cnt  <= cnt_upd;
            end
            if (accept) begin
                key_state <= sample;
            end
        end
    end

`ifdef FINAL_SOC_KEY_POLLER_IRQ_EN
    // Sticky interrupt: rises together with key_press; an ack only clears it
    // in a cycle where no press pulse is visible, so a press always wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (press_next != 4'd0) begin
            irq <= 1'b1;
        end else if (irq_ack && (key_press == 4'd0)) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_final_soc_key_poller.sv
module tb_final_soc_key_poller;

  localparam int POLL_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int ACTIVE_LOW   = 1;

  logic        clk;
  logic        reset;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [3:0]  key_state;
  logic [3:0]  key_press;
  logic [3:0]  key_release;
`ifdef FINAL_SOC_KEY_POLLER_IRQ_EN
  logic        irq;
  logic        irq_ack;
`endif

  final_soc_key_poller #(
    .POLL_DIV     (POLL_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .ACTIVE_LOW   (ACTIVE_LOW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .key_state       (key_state),
    .key_press       (key_press),
    .key_release     (key_release)
`ifdef FINAL_SOC_KEY_POLLER_IRQ_EN
    ,
    .irq             (irq),
    .irq_ack         (irq_ack)
`endif
  );

  // ---------------------------------------------------------------------------
  // Clock / cycle counter / watchdog
  // ---------------------------------------------------------------------------
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: history of accepted-poll samples. A change is accepted
  // when the newest DEBOUNCE_CNT samples are all identical and differ from
  // the debounced state. Reset leaves one implicit all-released sample.
  // ---------------------------------------------------------------------------
  logic [3:0] hist[$];
  logic [3:0] m_ks;
  logic       m_irq;
  int         last_read_cyc;
  int         exp_gap;

  task automatic model_reset();
    hist.delete();
    hist.push_back(4'd0);
    m_ks  = 4'd0;
    m_irq = 1'b0;
  endtask

  task automatic model_capture(input logic [3:0] s, output logic [3:0] p, output logic [3:0] r);
    bit run_ok;
    hist.push_back(s);
    if (hist.size() > 20) void'(hist.pop_front());
    run_ok = (hist.size() >= DEBOUNCE_CNT);
    for (int i = 0; i < DEBOUNCE_CNT && run_ok; i++) begin
      if (hist[hist.size() - 1 - i] != s) run_ok = 1'b0;
    end
    p = 4'd0;
    r = 4'd0;
    if (run_ok && s != m_ks) begin
      p    = s & ~m_ks;
      r    = ~s & m_ks;
      m_ks = s;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: serve one poll. Called at a negedge; returns at a negedge two
  // cycles after the capture edge. raw is the nibble the slave returns,
  // w the number of waitrequest stall cycles.
  // ---------------------------------------------------------------------------
  task automatic do_poll(input logic [3:0] raw, input int w, input bit ack_on_pulse,
                         output logic [3:0] ks, output logic [3:0] p, output logic [3:0] r);
    int          guard;
    int          read_cyc;
    logic [31:0] tmp;
    logic [3:0]  s;
    logic [3:0]  mp;
    logic [3:0]  mr;
    ks = 4'hx;
    p  = 4'hx;
    r  = 4'hx;
    guard = 0;
    while (avm_read !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) begin
      check("read_timeout", 32'(guard), 32'd0);
      return;
    end
    check("poll_gap", 32'(cyc - last_read_cyc), 32'(exp_gap));
    check("avm_address", 32'(avm_address), 32'd0);
    read_cyc     = cyc;
    avm_readdata = $urandom();
    for (int i = 0; i < w; i++) begin
      avm_waitrequest = 1'b1;
      @(negedge clk);
      check("read_held", 32'(avm_read), 32'd1);
      check("addr_held", 32'(avm_address), 32'd0);
      avm_readdata = $urandom();
    end
    avm_waitrequest = 1'b0;
    @(negedge clk);
    // CAPTURE cycle: read data valid now, request already dropped
    check("read_drop", 32'(avm_read), 32'd0);
    tmp          = $urandom();
    tmp[3:0]     = raw;
    avm_readdata = tmp;
    @(negedge clk);
    avm_readdata = $urandom();
    s = (ACTIVE_LOW != 0) ? ~raw : raw;
    model_capture(s, mp, mr);
    ks = key_state;
    p  = key_press;
    r  = key_release;
    check("key_state", 32'(key_state), 32'(m_ks));
    check("key_press", 32'(key_press), 32'(mp));
    check("key_release", 32'(key_release), 32'(mr));
`ifdef FINAL_SOC_KEY_POLLER_IRQ_EN
    if (mp != 4'd0) m_irq = 1'b1;
    check("irq_on_pulse", 32'(irq), 32'(m_irq));
    irq_ack = ack_on_pulse;
`endif
    @(negedge clk);
`ifdef FINAL_SOC_KEY_POLLER_IRQ_EN
    if (ack_on_pulse && mp == 4'd0) m_irq = 1'b0;
    irq_ack = 1'b0;
    check("irq_after_pulse", 32'(irq), 32'(m_irq));
`else
    if (ack_on_pulse) check("ack_unused", 32'(key_state), 32'(m_ks));
`endif
    check("press_one_cycle", 32'(key_press), 32'd0);
    check("release_one_cycle", 32'(key_release), 32'd0);
    last_read_cyc = read_cyc;
    exp_gap       = POLL_DIV + w + 2;
  endtask

  task automatic release_reset();
    reset = 1'b0;
    model_reset();
    last_read_cyc = cyc;
    exp_gap       = POLL_DIV;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] raw;
    int         w;
    logic [3:0] ks;
    logic [3:0] kp;
    logic [3:0] kr;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [3:0] ks;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] raw;
    int         guard;

    // stable all-released, then a 2-poll glitch, then a real press of key 0
    tbl[0]  = '{4'hF, 0, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{4'hF, 0, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{4'hE, 0, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{4'hE, 0, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{4'hF, 0, 4'h0, 4'h0, 4'h0};
    tbl[5]  = '{4'hE, 0, 4'h0, 4'h0, 4'h0};
    tbl[6]  = '{4'hE, 5, 4'h0, 4'h0, 4'h0};
    tbl[7]  = '{4'hE, 0, 4'h1, 4'h1, 4'h0};
    tbl[8]  = '{4'hE, 0, 4'h1, 4'h0, 4'h0};
    // key 0 released and key 1 pressed in the same poll
    tbl[9]  = '{4'hD, 0, 4'h1, 4'h0, 4'h0};
    tbl[10] = '{4'hD, 2, 4'h1, 4'h0, 4'h0};
    tbl[11] = '{4'hD, 0, 4'h2, 4'h2, 4'h1};
    // key 1 released, key 2 pressed
    tbl[12] = '{4'hB, 0, 4'h2, 4'h0, 4'h0};
    tbl[13] = '{4'hB, 1, 4'h2, 4'h0, 4'h0};
    tbl[14] = '{4'hB, 0, 4'h4, 4'h4, 4'h2};

    // ---- reset ----
    reset           = 1'b1;
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'h0000_000F;
`ifdef FINAL_SOC_KEY_POLLER_IRQ_EN
    irq_ack         = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_avm_read", 32'(avm_read), 32'd0);
    check("rst_key_state", 32'(key_state), 32'd0);
    check("rst_key_press", 32'(key_press), 32'd0);
    check("rst_key_release", 32'(key_release), 32'd0);
`ifdef FINAL_SOC_KEY_POLLER_IRQ_EN
    check("rst_irq", 32'(irq), 32'd0);
`endif
    release_reset();

    // ---- table ----
    for (int i = 0; i < 15; i++) begin
      do_poll(tbl[i].raw, tbl[i].w, 1'b0, ks, p, r);
      check($sformatf("tbl%0d_state", i), 32'(ks), 32'(tbl[i].ks));
      check($sformatf("tbl%0d_press", i), 32'(p), 32'(tbl[i].kp));
      check($sformatf("tbl%0d_release", i), 32'(r), 32'(tbl[i].kr));
    end

`ifdef FINAL_SOC_KEY_POLLER_IRQ_EN
    // ack with no press pending clears irq on the following edge
    check("irq_before_ack", 32'(irq), 32'd1);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    m_irq   = 1'b0;
    check("irq_acked", 32'(irq), 32'd0);
`endif

    // ---- key 3 press with an ack landing on the press pulse ----
    do_poll(4'h7, 0, 1'b0, ks, p, r);
    do_poll(4'h7, 1, 1'b0, ks, p, r);
    do_poll(4'h7, 0, 1'b1, ks, p, r);
    check("k3_state", 32'(ks), 32'h8);
    check("k3_press", 32'(p), 32'h8);
    check("k3_release", 32'(r), 32'h4);
`ifdef FINAL_SOC_KEY_POLLER_IRQ_EN
    check("irq_press_wins", 32'(irq), 32'd1);
`endif

    // ---- reset in the middle of a stalled read ----
    guard = 0;
    while (avm_read !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    check("midread_seen", 32'(avm_read), 32'd1);
    avm_waitrequest = 1'b1;
    @(negedge clk);
    check("midread_stalled", 32'(avm_read), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midread_rst_read", 32'(avm_read), 32'd0);
    check("midread_rst_state", 32'(key_state), 32'd0);
    check("midread_rst_press", 32'(key_press), 32'd0);
    check("midread_rst_release", 32'(key_release), 32'd0);
`ifdef FINAL_SOC_KEY_POLLER_IRQ_EN
    check("midread_rst_irq", 32'(irq), 32'd0);
`endif
    avm_waitrequest = 1'b0;
    release_reset();

    // ---- randomized polls against the model ----
    raw = 4'hF;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 3) raw = 4'($urandom_range(0, 15));
      do_poll(raw, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ks, p, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
